// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: FSM states, buffer entry layout and PC step.
// Entry fields are XLEN wide; fetch_stage's WIDTH parameter is expected to match XLEN.
package fetch_pkg;

    localparam int              XLEN   = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        S_START,
        S_RUN,
        S_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular FIFO of fetch entries between imem and decode; DEPTH must be a power of two >= 2.
// Flush has priority over push/pop and empties the queue in one cycle.
import fetch_pkg::*;

module fetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            // NOTE: storage is reset because the head outputs must read as zero right after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC, start/run/halt FSM, redirect handling and valid/ready glue to decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count/stall_count outputs.
import fetch_pkg::*;

module fetch_stage #(
    parameter int               WIDTH     = 32,
    parameter int               SIZE      = 23,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rd,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             halt_req,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] instr_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_count,
    output logic [31:0]      stall_count
`endif
);

    // The imem word index pc[SIZE+1:2] must fit inside the PC.
    if (SIZE + 2 > WIDTH) begin : g_size_exceeds_width
    end

    fetch_state_e     r_state;
    logic [WIDTH-1:0] r_pc;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;
    logic             w_full;
    logic             w_empty;
    logic             w_redirect;
    logic             w_enq;
    logic             w_deq;

    // Redirects arriving before the first fetch are ignored.
    assign w_redirect  = redirect_valid && (r_state != S_START);
    assign instr_valid = !w_empty && !redirect_valid;
    assign w_deq       = instr_valid && instr_ready;
    assign w_enq       = (r_state == S_RUN) && !halt_req && !redirect_valid && (!w_full || w_deq);
    assign w_push_data = '{pc: r_pc, instr: imem_rd};

    fetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buffer (
        .clk      (clk),
        .reset    (reset),
        .push     (w_enq),
        .pop      (w_deq),
        .flush    (w_redirect),
        .push_data(w_push_data),
        .head     (w_head),
        .full     (w_full),
        .empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_START;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                S_START: r_state <= S_RUN;
                S_RUN:   if (halt_req)  r_state <= S_HALT;
                S_HALT:  if (!halt_req) r_state <= S_RUN;
                default: r_state <= S_START;
            endcase
            if (w_redirect) begin
                r_pc <= {redirect_target[WIDTH-1:2], 2'b00};
            end else if (w_enq) begin
                r_pc <= r_pc + PC_INC;
            end
        end
    end

    assign imem_addr = r_pc;

    // Head fields read as zero whenever the buffer holds nothing.
    assign instr          = w_empty ? '0 : w_head.instr;
    assign instr_pc       = w_empty ? '0 : w_head.pc;
    assign instr_pc_plus4 = w_empty ? '0 : w_head.pc + PC_INC;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;
    logic        w_stall;

    assign w_stall = (r_state == S_RUN) && !halt_req && !redirect_valid && w_full && !w_deq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_enq && (r_fetch_count != '1)) r_fetch_count <= r_fetch_count + 1'b1;
            if (w_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] SALT  = 32'h5A00_00C3;
    localparam int          MODE_START = 0;
    localparam int          MODE_RUN   = 1;
    localparam int          MODE_HALT  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic        halt_req = 1'b0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] redirect_target = '0;
    logic [31:0] imem_addr, imem_rd, instr, instr_pc, instr_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    always #5 clk = ~clk;

    // imem model: every word is a scrambled copy of its own address.
    assign imem_rd = imem_addr ^ SALT;

    fetch_stage #(
        .WIDTH    (32),
        .SIZE     (23),
        .RESET_PC (32'h0),
        .BUF_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %08h expected %08h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: mode, PC and an in-order queue of fetched {pc, instr} pairs.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_q_pc[$];
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    task automatic model_reset();
        m_mode = MODE_START;
        m_pc   = 32'h0;
        m_q_pc.delete();
        m_fetch = '0;
        m_stall = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        instr_ready = 1'b0;
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_pc4", instr_pc_plus4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_fetch_cnt", fetch_count, 32'h0);
        check("rst_stall_cnt", stall_count, 32'h0);
`endif
    endtask

    task automatic step(input logic rdy, input logic hlt, input logic rdr, input logic [31:0] tgt);
        bit exp_valid, deq, enq, stall;
        @(negedge clk);
        instr_ready = rdy;
        halt_req = hlt;
        redirect_valid = rdr;
        redirect_target = tgt;
        #1;
        exp_valid = (m_q_pc.size() != 0) && !rdr;
        deq   = exp_valid && rdy;
        enq   = (m_mode == MODE_RUN) && !hlt && !rdr && ((m_q_pc.size() < DEPTH) || deq);
        stall = (m_mode == MODE_RUN) && !hlt && !rdr && (m_q_pc.size() == DEPTH) && !deq;
        check("imem_addr", imem_addr, m_pc);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            check("instr_pc", instr_pc, m_q_pc[0]);
            check("instr", instr, m_q_pc[0] ^ SALT);
            check("instr_pc_plus4", instr_pc_plus4, m_q_pc[0] + 32'd4);
        end
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, m_fetch);
        check("stall_count", stall_count, m_stall);
`endif
        @(posedge clk);
        cyc++;
        if (rdr && (m_mode != MODE_START)) begin
            m_q_pc.delete();
            m_pc = tgt & ~32'h3;
        end else begin
            if (deq) void'(m_q_pc.pop_front());
            if (enq) begin
                m_q_pc.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        if (enq && (m_fetch != '1)) m_fetch++;
        if (stall && (m_stall != '1)) m_stall++;
        case (m_mode)
            MODE_START: m_mode = MODE_RUN;
            MODE_RUN:   if (hlt) m_mode = MODE_HALT;
            default:    if (!hlt) m_mode = MODE_RUN;
        endcase
    endtask

    initial begin
        logic h;
        model_reset();

        // Streaming with decode always ready; an early redirect lands in S_START and is ignored.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 32'h0000_0500);
        repeat (8) step(1'b1, 1'b0, 1'b0, '0);

        // Back-pressure fills the buffer, then streaming resumes without gap or duplicate.
        do_reset();
        repeat (5) step(1'b0, 1'b0, 1'b0, '0);
        check("full_pc_held", imem_addr, 32'h8);
        repeat (6) step(1'b1, 1'b0, 1'b0, '0);

        // Redirect to an unaligned target while full: old entries are flushed.
        repeat (4) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
        repeat (4) step(1'b1, 1'b0, 1'b0, '0);

        // Halt with two entries buffered: drain, hold PC, then resume; also redirect while halted.
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        repeat (4) step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        repeat (2) step(1'b1, 1'b1, 1'b0, '0);
        repeat (4) step(1'b1, 1'b0, 1'b0, '0);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        repeat (4) step(1'b1, 1'b0, 1'b0, '0);

        // Counters across a back-pressure episode, then reset mid-stream.
        do_reset();
        repeat (5) step(1'b0, 1'b0, 1'b0, '0);
        repeat (6) step(1'b1, 1'b0, 1'b0, '0);
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0, '0);

        // Randomized traffic.
        h = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            if ($urandom_range(0, 9) == 0) h = ~h;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                h = 1'b0;
            end else begin
                step($urandom_range(0, 9) < 7, h, $urandom_range(0, 11) == 0, tgt);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
